// File: rtl/key_press_conditioner_if.sv
// rtl/key_press_conditioner_if.sv - key conditioner signal bundle
// Groups the raw key, the pulse gate and the conditioned outputs.
interface key_press_conditioner_if;
  logic i_key_n;
  logic i_enable;
  logic o_pressed;
  logic o_pull;
  logic o_release;

  modport master (
    output i_key_n,
    output i_enable,
    input  o_pressed,
    input  o_pull,
    input  o_release
  );

  modport slave (
    input  i_key_n,
    input  i_enable,
    output o_pressed,
    output o_pull,
    output o_release
  );
endinterface

// File: rtl/key_press_conditioner.sv
// rtl/key_press_conditioner.sv - synchronize, debounce and pulse a pushbutton
// One pull per accepted press, one release per accepted release.
module key_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input logic                    i_clock,
  input logic                    i_reset,
  key_press_conditioner_if.slave kp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO  = '0;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_pressed;
  logic             r_pull;
  logic             r_release;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_hit;
  logic             w_first_hit;
  logic             w_pressed_nxt;
  logic             w_pull_nxt;
  logic             w_release_nxt;

  always_comb begin
    w_count_inc   = (r_count >= LIMIT) ? r_count : r_count + ONE;
    w_hit         = (w_count_inc >= LIMIT);
    // A single-sample debounce accepts on the very first differing sample.
    w_first_hit   = (LIMIT <= ONE);
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_pressed_nxt = r_pressed;
    w_pull_nxt    = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          if (w_first_hit) begin
            w_state_nxt   = S_HELD;
            w_count_nxt   = ZERO;
            w_pressed_nxt = 1'b1;
            w_pull_nxt    = kp.i_enable;
          end else begin
            w_state_nxt = S_PRESS_WAIT;
            w_count_nxt = ONE;
          end
        end
      end
      S_PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = ZERO;
        end else if (w_hit) begin
          w_state_nxt   = S_HELD;
          w_count_nxt   = ZERO;
          w_pressed_nxt = 1'b1;
          w_pull_nxt    = kp.i_enable;
        end else begin
          w_count_nxt = w_count_inc;
        end
      end
      S_HELD: begin
        if (r_sync2) begin
          if (w_first_hit) begin
            w_state_nxt   = S_IDLE;
            w_count_nxt   = ZERO;
            w_pressed_nxt = 1'b0;
            w_release_nxt = kp.i_enable;
          end else begin
            w_state_nxt = S_RELEASE_WAIT;
            w_count_nxt = ONE;
          end
        end
      end
      S_RELEASE_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = S_HELD;
          w_count_nxt = ZERO;
        end else if (w_hit) begin
          w_state_nxt   = S_IDLE;
          w_count_nxt   = ZERO;
          w_pressed_nxt = 1'b0;
          w_release_nxt = kp.i_enable;
        end else begin
          w_count_nxt = w_count_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = ZERO;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_count   <= ZERO;
      r_pressed <= 1'b0;
      r_pull    <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= kp.i_key_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_pressed <= w_pressed_nxt;
      r_pull    <= w_pull_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign kp.o_pressed = r_pressed;
  assign kp.o_pull    = r_pull;
  assign kp.o_release = r_release;

endmodule

// File: tb/tb_key_press_conditioner.sv
// tb/tb_key_press_conditioner.sv - scoreboard bench for key_press_conditioner
// Expected output events are queued as keys are driven and popped on arrival.
module tb_key_press_conditioner;
  localparam int DC    = 4;
  localparam int CNT_W = 3;

  typedef struct {
    int unsigned at_edge;
    logic [2:0]  outs;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  key_press_conditioner_if kif();

  key_press_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CNT_W)
  ) dut (
    .i_clock(clk),
    .i_reset(rstn),
    .kp(kif)
  );

  ev_t         sb_q[$];
  int unsigned cyc = 0;
  logic        last_rst = 1'b0;
  bit          started = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic        acc = 1'b0;
  int          run = 0;
  logic        prev_pressed = 1'b0;
  logic [2:0]  obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  // Acceptance happens two edges after the DC-th consecutive differing sample.
  task automatic drive(input logic k, input logic en, input logic rn);
    ev_t ev;
    kif.i_key_n  = k;
    kif.i_enable = en;
    rstn         = rn;
    @(posedge clk);
    cyc++;
    last_rst = !rn;
    started  = 1'b1;
    if (!rn) begin
      acc = 1'b0;
      run = 0;
      while (sb_q.size() > 0 && sb_q[$].at_edge >= cyc) void'(sb_q.pop_back());
    end else if (!k != acc) begin
      run++;
      if (run == DC) begin
        acc = !acc;
        run = 0;
        ev.at_edge = cyc + 2;
        ev.outs    = {acc, acc & en, !acc & en};
        sb_q.push_back(ev);
      end
    end else begin
      run = 0;
    end
    #1;
  endtask

  task automatic hold(input logic k, input logic en, input int n);
    for (int i = 0; i < n; i++) drive(k, en, 1'b1);
  endtask

  always @(negedge clk) begin
    if (started) begin
      ev_t ev;
      obs = {kif.o_pressed, kif.o_pull, kif.o_release};
      if (last_rst) begin
        check("reset_outs", {29'd0, obs}, 32'd0);
      end else if (sb_q.size() > 0 && sb_q[0].at_edge == cyc) begin
        ev = sb_q.pop_front();
        check("event", {29'd0, obs}, {29'd0, ev.outs});
      end else if (obs[1] || obs[0] || (obs[2] != prev_pressed)) begin
        check("unexpected", {29'd0, obs}, {29'd0, prev_pressed, 2'b00});
      end
      prev_pressed = obs[2];
    end
  end

  initial begin
    int len;
    logic k;
    kif.i_key_n  = 1'b1;
    kif.i_enable = 1'b1;

    // reset held with key pressed, then released
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 8);
    check("drain_reset", sb_q.size(), 0);

    // clean long press
    hold(1'b0, 1'b1, 20);
    hold(1'b1, 1'b1, 10);
    check("drain_clean", sb_q.size(), 0);

    // press bounce
    hold(1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 1);
    hold(1'b0, 1'b1, 2);
    hold(1'b1, 1'b1, 1);
    hold(1'b0, 1'b1, 8);
    hold(1'b1, 1'b1, 8);
    check("drain_bounce", sb_q.size(), 0);

    // release glitch while held
    hold(1'b0, 1'b1, 8);
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b1, 6);
    hold(1'b1, 1'b1, 8);
    check("drain_glitch", sb_q.size(), 0);

    // pulses suppressed, pressed still tracks
    hold(1'b0, 1'b0, 8);
    hold(1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 8);
    hold(1'b0, 1'b1, 6);
    hold(1'b1, 1'b1, 8);
    check("drain_enable", sb_q.size(), 0);

    // reset lands on the accepting edge
    hold(1'b0, 1'b1, 5);
    drive(1'b0, 1'b1, 1'b0);
    hold(1'b1, 1'b1, 8);
    check("drain_rst_mid", sb_q.size(), 0);

    // single-sample debounce boundary never applies here; exercise random runs
    k = 1'b1;
    for (int i = 0; i < 16; i++) begin
      k = ~k;
      len = $urandom_range(1, 7);
      hold(k, 1'b1, len);
    end
    hold(1'b1, 1'b1, 8);
    check("drain_random", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
